// File: rtl/axi_common_defs.sv
// Purpose : shared types and phase indices for the AXI4 byte-access test sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package axi_common_defs;

    // Sequencer FSM encoding; 3 bits leaves room for future states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_FINISH = 3'd4,
        ST_ERROR  = 3'd5
    } phase_seq_state_t;

    // Phase slot indices as wired to the phase control modules.
    localparam int PH_WRITE       = 0;
    localparam int PH_READ        = 1;
    localparam int PH_BYTE_VERIFY = 2;

endpackage

// File: rtl/axi_test_phase_sequencer_if.sv
// Purpose : run-control and phase start/done bundle between sequencer and phase controllers.
// Latency : wires only.
// Backpressure: none; phase_done is the only return path (pulse or level).
// Ports   : master = sequencer side (drives starts/status), slave = environment side.
interface axi_test_phase_sequencer_if #(
    parameter int NUM_PHASES     = 3,
    parameter int TEST_CNT_WIDTH = 16
);
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic                      run_start;
    logic                      abort;
    logic [TEST_CNT_WIDTH-1:0] num_tests;
    logic [NUM_PHASES-1:0]     phase_enable;
    logic [NUM_PHASES-1:0]     phase_done;
    logic [NUM_PHASES-1:0]     phase_start;
    logic                      clear_phase_latches;
    logic                      busy;
    logic [TEST_CNT_WIDTH-1:0] test_index;
    logic [PH_W-1:0]           cur_phase;
    logic                      run_done;
    logic                      run_error;
    logic [PH_W-1:0]           error_phase;

    modport master (
        input  run_start, abort, num_tests, phase_enable, phase_done,
        output phase_start, clear_phase_latches, busy, test_index,
               cur_phase, run_done, run_error, error_phase
    );

    modport slave (
        output run_start, abort, num_tests, phase_enable, phase_done,
        input  phase_start, clear_phase_latches, busy, test_index,
               cur_phase, run_done, run_error, error_phase
    );

endinterface

// File: rtl/axi_phase_watchdog.sv
// Purpose : cycle counter with clear/enable, flags when LIMIT-1 is reached (LIMIT=0 never expires).
// Latency : count updates one cycle after en_i; expired_o is decoded from the registered count.
// Backpressure: none.
// Ports   : clk, rst (sync, active-high), clr_i (load zero, wins over en_i), en_i (count up), expired_o.
module axi_phase_watchdog #(
    parameter int LIMIT = 100000,
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/axi_test_phase_sequencer.sv
// Purpose : steps each test through its enabled phases (start pulse, wait done, clear pulse), with watchdog.
// Latency : run_start -> phase_start next cycle; phase_done -> clear next cycle -> next phase_start after that.
// Backpressure: none; a phase simply holds the sequencer in WAIT until its done bit or the timeout.
// Ports   : clk, rst (sync, active-high), bus (master modport: run control in, phase start/status out).
module axi_test_phase_sequencer
    import axi_common_defs::*;
#(
    parameter int NUM_PHASES     = 3,
    parameter int TEST_CNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TO_CNT_WIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    axi_test_phase_sequencer_if.master  bus
);
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    phase_seq_state_t          state_q;
    logic [TEST_CNT_WIDTH-1:0] num_tests_q;
    logic [NUM_PHASES-1:0]     phase_en_q;
    logic                      done_lat_q;
    logic [NUM_PHASES-1:0]     phase_start_q;
    logic                      clear_q;
    logic                      busy_q;
    logic [TEST_CNT_WIDTH-1:0] test_index_q;
    logic [PH_W-1:0]           cur_phase_q;
    logic                      run_done_q;
    logic                      run_error_q;
    logic [PH_W-1:0]           error_phase_q;

    logic [PH_W:0]             launch_hit;   // lowest enabled phase of the incoming mask
    logic [PH_W:0]             first_hit;    // lowest enabled phase of the captured mask
    logic [PH_W:0]             next_hit;     // next enabled phase above cur_phase_q
    logic                      cur_done;
    logic                      last_test;
    logic                      wd_expired;

    // Priority search: {found, index} of the lowest set bit of mask at or above 'from'.
    function automatic logic [PH_W:0] find_enabled(input logic [NUM_PHASES-1:0] mask,
                                                   input int from);
        logic [PH_W:0] res;
        res = '0;
        for (int i = NUM_PHASES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                res = {1'b1, PH_W'(i)};
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_PHASES-1:0] onehot(input logic [PH_W-1:0] idx);
        logic [NUM_PHASES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        launch_hit = find_enabled(bus.phase_enable, 0);
        first_hit  = find_enabled(phase_en_q, 0);
        next_hit   = find_enabled(phase_en_q, int'(cur_phase_q) + 1);
        // Only the current phase's bit counts, so a stale level on another phase is harmless.
        cur_done   = bus.phase_done[cur_phase_q];
        last_test  = (test_index_q == (num_tests_q - TEST_CNT_WIDTH'(1)));
    end

    // Watchdog restarts on every START and only counts while waiting.
    axi_phase_watchdog #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (TO_CNT_WIDTH)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == ST_START),
        .en_i      (state_q == ST_WAIT),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.abort) begin
            state_q       <= ST_IDLE;
            done_lat_q    <= 1'b0;
            phase_start_q <= '0;
            clear_q       <= 1'b0;
            busy_q        <= 1'b0;
            test_index_q  <= '0;
            cur_phase_q   <= '0;
            run_done_q    <= 1'b0;
            run_error_q   <= 1'b0;
            error_phase_q <= '0;
            if (rst) begin
                num_tests_q <= '0;
                phase_en_q  <= '0;
            end
        end else begin
            // Pulsed outputs default low every cycle.
            phase_start_q <= '0;
            clear_q       <= 1'b0;

            if (((state_q == ST_START) || (state_q == ST_WAIT)) && cur_done) begin
                done_lat_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE, ST_FINISH, ST_ERROR: begin
                    if (bus.run_start) begin
                        num_tests_q  <= bus.num_tests;
                        phase_en_q   <= bus.phase_enable;
                        run_done_q   <= 1'b0;
                        run_error_q  <= 1'b0;
                        test_index_q <= '0;
                        if ((bus.num_tests == '0) || !launch_hit[PH_W]) begin
                            state_q    <= ST_FINISH;
                            run_done_q <= 1'b1;
                            busy_q     <= 1'b0;
                        end else begin
                            cur_phase_q   <= launch_hit[PH_W-1:0];
                            phase_start_q <= onehot(launch_hit[PH_W-1:0]);
                            busy_q        <= 1'b1;
                            state_q       <= ST_START;
                        end
                    end
                end

                ST_START: begin
                    // A done coincident with the start pulse completes the phase immediately.
                    if (cur_done) begin
                        clear_q <= 1'b1;
                        state_q <= ST_CLEAR;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (done_lat_q || cur_done) begin
                        clear_q <= 1'b1;
                        state_q <= ST_CLEAR;
                    end else if (wd_expired) begin
                        run_error_q   <= 1'b1;
                        error_phase_q <= cur_phase_q;
                        busy_q        <= 1'b0;
                        state_q       <= ST_ERROR;
                    end
                end

                ST_CLEAR: begin
                    done_lat_q <= 1'b0;
                    if (next_hit[PH_W]) begin
                        cur_phase_q   <= next_hit[PH_W-1:0];
                        phase_start_q <= onehot(next_hit[PH_W-1:0]);
                        state_q       <= ST_START;
                    end else if (last_test) begin
                        run_done_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_FINISH;
                    end else begin
                        test_index_q  <= test_index_q + TEST_CNT_WIDTH'(1);
                        cur_phase_q   <= first_hit[PH_W-1:0];
                        phase_start_q <= onehot(first_hit[PH_W-1:0]);
                        state_q       <= ST_START;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.phase_start         = phase_start_q;
    assign bus.clear_phase_latches = clear_q;
    assign bus.busy                = busy_q;
    assign bus.test_index          = test_index_q;
    assign bus.cur_phase           = cur_phase_q;
    assign bus.run_done            = run_done_q;
    assign bus.run_error           = run_error_q;
    assign bus.error_phase         = error_phase_q;

endmodule

// File: tb/tb_axi_test_phase_sequencer.sv
// Purpose : directed bench for axi_test_phase_sequencer with an auto-responding phase model.
// Latency : all timing expectations are absolute cycle numbers derived from the run_start cycle.
// Backpressure: phase_done is produced by a per-phase delay table or driven by hand.
module tb_axi_test_phase_sequencer;

    logic        clk;
    logic        rst;
    logic        run_start;
    logic        abort;
    logic [15:0] num_tests;
    logic [2:0]  phase_enable;
    logic [2:0]  man_done;
    logic [2:0]  auto_done;
    logic        auto_en;

    int cyc;
    int dly[3];
    int cd[3];
    int checks;
    int errors;

    logic [2:0] st_val_q[$];
    int         st_cyc_q[$];
    int         st_tidx_q[$];
    int         clr_cyc_q[$];

    axi_test_phase_sequencer_if #(.NUM_PHASES(3), .TEST_CNT_WIDTH(16)) bus_if ();

    assign bus_if.run_start    = run_start;
    assign bus_if.abort        = abort;
    assign bus_if.num_tests    = num_tests;
    assign bus_if.phase_enable = phase_enable;
    assign bus_if.phase_done   = auto_en ? auto_done : man_done;

    axi_test_phase_sequencer #(
        .NUM_PHASES     (3),
        .TEST_CNT_WIDTH (16),
        .TIMEOUT_CYCLES (16),
        .TO_CNT_WIDTH   (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Phase model + logger: runs 1 time unit after each rising edge.
    initial begin
        cyc       = 0;
        auto_done = '0;
        for (int p = 0; p < 3; p++) cd[p] = -1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            auto_done = '0;
            for (int p = 0; p < 3; p++) begin
                if (cd[p] > 0) begin
                    cd[p]--;
                    if (cd[p] == 0) begin
                        auto_done[p] = 1'b1;
                        cd[p] = -1;
                    end
                end
            end
            if (bus_if.phase_start != 3'b000) begin
                st_val_q.push_back(bus_if.phase_start);
                st_cyc_q.push_back(cyc);
                st_tidx_q.push_back(int'(bus_if.test_index));
                for (int p = 0; p < 3; p++) begin
                    if (bus_if.phase_start[p]) begin
                        if (dly[p] == 0) auto_done[p] = 1'b1;
                        else if (dly[p] > 0) cd[p] = dly[p];
                    end
                end
            end
            if (bus_if.clear_phase_latches) clr_cyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise run_start for one edge; 'at' is the cycle before the sampling edge.
    task automatic kick(input logic [15:0] n, input logic [2:0] en, output int at);
        num_tests    = n;
        phase_enable = en;
        run_start    = 1'b1;
        at           = cyc;
        tick(1);
        run_start    = 1'b0;
    endtask

    // sel 0 waits for run_done, sel 1 for run_error; at = -1 if the budget runs out.
    task automatic wait_for(input int sel, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget && at < 0; i++) begin
            if ((sel == 0 && bus_if.run_done) || (sel == 1 && bus_if.run_error)) at = cyc;
            else tick(1);
        end
    endtask

    function automatic logic [26:0] out_vec();
        return {bus_if.phase_start, bus_if.clear_phase_latches, bus_if.busy,
                bus_if.run_done, bus_if.run_error, bus_if.test_index,
                bus_if.cur_phase, bus_if.error_phase};
    endfunction

    initial begin
        int n0;
        int at;
        int sb;
        int cb;
        logic [2:0] exp1[6];

        checks = 0;
        errors = 0;
        rst = 1'b1; run_start = 1'b0; abort = 1'b0;
        num_tests = '0; phase_enable = '0; man_done = '0; auto_en = 1'b1;
        for (int p = 0; p < 3; p++) dly[p] = 3;
        exp1[0] = 3'b001; exp1[1] = 3'b010; exp1[2] = 3'b100;
        exp1[3] = 3'b001; exp1[4] = 3'b010; exp1[5] = 3'b100;

        tick(3);
        chk("rst_outputs", out_vec(), 0);
        rst = 1'b0;
        tick(2);
        chk("idle_outputs", out_vec(), 0);

        // Two tests, all phases, done 3 cycles after each start; config changes mid-run ignored.
        sb = st_val_q.size(); cb = clr_cyc_q.size();
        kick(2, 3'b111, n0);
        num_tests = 16'd5; phase_enable = 3'b010;
        chk("t1_busy", bus_if.busy, 1);
        wait_for(0, 100, at);
        chk("t1_done_cyc", at, n0 + 31);
        chk("t1_nstarts", st_val_q.size() - sb, 6);
        chk("t1_nclears", clr_cyc_q.size() - cb, 6);
        for (int i = 0; i < 6; i++) begin
            chk("t1_start_val", st_val_q[sb + i], exp1[i]);
            chk("t1_start_cyc", st_cyc_q[sb + i], n0 + 1 + 5 * i);
            chk("t1_start_tidx", st_tidx_q[sb + i], i / 3);
        end
        chk("t1_clr_first", clr_cyc_q[cb], n0 + 5);
        chk("t1_clr_last", clr_cyc_q[cb + 5], n0 + 30);
        chk("t1_tidx_end", bus_if.test_index, 1);
        chk("t1_busy_end", bus_if.busy, 0);

        // Sparse enable 101: phase 1 skipped.
        sb = st_val_q.size();
        kick(1, 3'b101, n0);
        wait_for(0, 60, at);
        chk("t2_done_cyc", at, n0 + 11);
        chk("t2_nstarts", st_val_q.size() - sb, 2);
        chk("t2_start0", st_val_q[sb], 3'b001);
        chk("t2_start1", st_val_q[sb + 1], 3'b100);
        chk("t2_start1_cyc", st_cyc_q[sb + 1], n0 + 6);

        // Done coincident with the phase 0 start pulse.
        sb = st_val_q.size(); cb = clr_cyc_q.size();
        dly[0] = 0;
        kick(1, 3'b011, n0);
        wait_for(0, 60, at);
        chk("t3_clr_cyc", clr_cyc_q[cb], n0 + 2);
        chk("t3_next_start", st_cyc_q[sb + 1], n0 + 3);
        chk("t3_next_val", st_val_q[sb + 1], 3'b010);
        chk("t3_done_cyc", at, n0 + 8);
        dly[0] = 3;

        // Phase 1 never completes: watchdog error after 16 WAIT cycles.
        sb = st_val_q.size();
        dly[1] = -1;
        kick(1, 3'b111, n0);
        wait_for(1, 80, at);
        chk("t4_err_cyc", at, n0 + 23);
        chk("t4_err_phase", bus_if.error_phase, 1);
        chk("t4_busy", bus_if.busy, 0);
        chk("t4_run_done", bus_if.run_done, 0);
        tick(6);
        chk("t4_nstarts", st_val_q.size() - sb, 2);
        chk("t4_err_held", bus_if.run_error, 1);
        dly[1] = 3;
        sb = st_val_q.size();
        kick(1, 3'b001, n0);
        chk("t4_err_clr", bus_if.run_error, 0);
        chk("t4_restart_tidx", st_tidx_q[sb], 0);
        chk("t4_restart_cyc", st_cyc_q[sb], n0 + 1);
        wait_for(0, 40, at);
        chk("t4_restart_done", at, n0 + 6);

        // Empty runs finish immediately without start pulses.
        sb = st_val_q.size();
        kick(0, 3'b111, n0);
        chk("t5_zero_tests", {bus_if.run_done, bus_if.busy}, 2'b10);
        kick(3, 3'b000, n0);
        chk("t5_zero_mask", {bus_if.run_done, bus_if.busy}, 2'b10);
        tick(2);
        chk("t5_nstarts", st_val_q.size() - sb, 0);

        // Synchronous reset in the middle of WAIT.
        dly[0] = -1;
        kick(1, 3'b001, n0);
        tick(2);
        chk("t6_in_wait", bus_if.busy, 1);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_outs", out_vec(), 0);
        rst = 1'b0;
        sb = st_val_q.size();
        tick(3);
        chk("t6_idle", st_val_q.size() - sb, 0);

        // Foreign done ignored; abort wins over a same-cycle done.
        auto_en = 1'b0;
        for (int p = 0; p < 3; p++) dly[p] = -1;
        cb = clr_cyc_q.size();
        kick(1, 3'b111, n0);
        tick(1);
        man_done = 3'b100;
        tick(3);
        chk("t7_foreign_ignored", clr_cyc_q.size() - cb, 0);
        chk("t7_still_waiting", {bus_if.busy, bus_if.cur_phase}, 3'b100);
        man_done = 3'b101;
        abort = 1'b1;
        tick(1);
        chk("t7_abort_outs", out_vec(), 0);
        abort = 1'b0;
        man_done = 3'b000;
        sb = st_val_q.size();
        tick(3);
        chk("t7_no_clear", clr_cyc_q.size() - cb, 0);
        chk("t7_no_start", st_val_q.size() - sb, 0);
        auto_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
